data_mem_access_unit: RTL and testbench
=======================================

Name: data_mem_access_unit

Overview:
- Executes LOAD/STORE between the accumulator and external data memory, using the register file's DMAR as the address.
- Sits directly downstream of the register file: consumes dmar and acc_out, and feeds load results back through acc_in/acc_write_enable.
- Runs a req/ack handshake with a variable-latency memory and raises busy so control stalls while an access is in flight.

Parameters:
DATA_W, 8, data word width
D_ADDR_WIDTH, 12, data address width (matches DMAR)
TIMEOUT_CYCLES, 15, max cycles mem_req may stay unacknowledged (used only with DMEM_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
load_req  input  1  start load: mem[dmar] -> ACC
store_req  input  1  start store: acc_out -> mem[dmar]
dmar  input  D_ADDR_WIDTH  data address from register file
acc_out  input  DATA_W  accumulator value from register file
acc_in  output  DATA_W  load data to register file accumulator
acc_write_enable  output  1  one-cycle accumulator write strobe
busy  output  1  access in progress, so control must stall
done  output  1  one-cycle completion pulse
mem_req  output  1  memory request
mem_we  output  1  1 = write, 0 = read
mem_addr  output  D_ADDR_WIDTH  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid when mem_ack = 1
mem_ack  input  1  memory acknowledge, may be high in the first mem_req cycle
mem_error  output  1  one-cycle timeout pulse (tied 0 without DMEM_TIMEOUT_EN)

Behaviour:
- One clock, clk. reset_n is asynchronous and active-low.
- All outputs decode from registers only; there are no combinational input-to-output paths.
- Reset values:
  - state = IDLE.
  - acc_in, acc_write_enable, busy, done, mem_req, mem_we, mem_addr, mem_wdata, mem_error all = 0.
  - Internal op, rdata and timeout counter all = 0.
- States: IDLE, ACCESS, COMPLETE. busy = (state != IDLE).
- IDLE:
  - On a clk edge with load_req or store_req high: capture dmar -> mem_addr, acc_out -> mem_wdata, op -> mem_we; go to ACCESS.
  - If both requests are high, store wins and the load is dropped.
  - Requests are ignored in any state other than IDLE; there is no queuing.
- ACCESS:
  - mem_req = 1. mem_we, mem_addr and mem_wdata are held stable until ack.
  - On an edge with mem_ack = 1 and a load: register mem_rdata into rdata (drives acc_in), then go to COMPLETE.
  - On an edge with mem_ack = 1 and a store: go to COMPLETE.
  - mem_req drops in the cycle after ack is sampled.
- COMPLETE (exactly one cycle):
  - done = 1.
  - acc_write_enable = 1 only if the op was a load with no error; acc_in = rdata.
  - Then go to IDLE.
- Latency (request sampled at edge 0, zero-wait ack):
  - mem_req is high in cycle 1.
  - COMPLETE/done is in cycle 2.
  - The next request is accepted at edge 3, so the minimum is 3 cycles per access.
  - Each memory wait cycle adds 1.
- acc_in holds the last loaded value between loads.
- mem_addr and mem_wdata hold the last captured values while idle.
- Reset asserted mid-access: state returns to IDLE immediately (asynchronously), mem_req drops to 0, and no acc write or done pulse is produced. A mem_ack arriving after reset is ignored.
- Address and data are passed through without arithmetic, and widths must match exactly.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- With the macro defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments on each ACCESS cycle with mem_ack = 0.
  - When the counter reaches TIMEOUT_CYCLES and mem_ack is still 0, the access is aborted: go to COMPLETE with done = 1 and mem_error = 1 (one cycle), and acc_write_enable stays 0.
  - If mem_ack = 1 in the final allowed cycle, the ack wins.
- Without the macro: ACCESS waits indefinitely, the counter is not built, and mem_error is constant 0.

Test Plan:
- Reset, then load_req with dmar = 0x234 and memory returning 0xA5 with a zero-wait ack -> mem_req/mem_we = 1/0 and mem_addr = 0x234 in cycle 1; done and acc_write_enable high in cycle 2 with acc_in = 0xA5; busy low from cycle 3.
- store_req with dmar = 0x1FF, acc_out = 0x3C, and ack delayed 4 cycles -> mem_req high for 5 cycles; mem_we = 1, mem_addr = 0x1FF and mem_wdata = 0x3C stable throughout; done pulses once; acc_write_enable never asserts.
- load_req and store_req together -> store is performed (mem_we = 1); a load_req pulse during busy is ignored; exactly one done pulse.
- Reset asserted in the 2nd ACCESS cycle of a load -> mem_req and busy drop without waiting for an edge; no done and no acc_write_enable; a later ack is ignored; a subsequent load completes normally.
- With DMEM_TIMEOUT_EN, TIMEOUT_CYCLES = 15 and ack never arriving -> mem_req high for 15 cycles, then done = mem_error = 1 for one cycle and acc_write_enable = 0. A repeat run with ack in the 15th cycle completes normally with mem_error = 0.
- Back-to-back: load 0x010 then store 0x011, each requested at the first IDLE edge -> accesses 3 cycles apart, correct addresses, and acc_in retains the loaded value after the store.

Source files
------------

// File: rtl/data_mem_access_unit.sv
// LOAD/STORE engine between the accumulator and data memory using DMAR as address.
// Optional request timeout is built only when DMEM_TIMEOUT_EN is defined.
module data_mem_access_unit #(
  parameter int DATA_W         = 8,
  parameter int D_ADDR_WIDTH   = 12,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load_req,
  input  logic                    store_req,
  input  logic [D_ADDR_WIDTH-1:0] dmar,
  input  logic [DATA_W-1:0]       acc_out,
  output logic [DATA_W-1:0]       acc_in,
  output logic                    acc_write_enable,
  output logic                    busy,
  output logic                    done,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [D_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  input  logic                    mem_ack,
  output logic                    mem_error
);

  // state    | meaning
  // IDLE     | waiting for load_req / store_req
  // ACCESS   | mem_req asserted, waiting for mem_ack (or timeout)
  // COMPLETE | one-cycle done pulse, accumulator write for a good load
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    COMPLETE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    op_q, op_d;
  logic [D_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    timeout;

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The cycle that would bring the count to TIMEOUT_CYCLES is the last one allowed.
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !mem_ack;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef DMEM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_req || store_req) begin
          op_d    = store_req;
          addr_d  = dmar;
          wdata_d = acc_out;
          err_d   = 1'b0;
`ifdef DMEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          if (!op_q) begin
            rdata_d = mem_rdata;
          end
          state_d = COMPLETE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = COMPLETE;
        end
`ifdef DMEM_TIMEOUT_EN
        if (!mem_ack) begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      COMPLETE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef DMEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign busy             = (state_q != IDLE);
  assign mem_req          = (state_q == ACCESS);
  assign done             = (state_q == COMPLETE);
  assign acc_write_enable = (state_q == COMPLETE) && !op_q && !err_q;
  assign acc_in           = rdata_q;
  assign mem_we           = op_q;
  assign mem_addr         = addr_q;
  assign mem_wdata        = wdata_q;

`ifdef DMEM_TIMEOUT_EN
  assign mem_error = (state_q == COMPLETE) && err_q;
`else
  assign mem_error = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Scoreboard bench for data_mem_access_unit: reference memory/accumulator model,
// randomized memory latency, directed corner cases (timeout cases under DMEM_TIMEOUT_EN).
`timescale 1ns/1ps
module tb_data_mem_access_unit;
  localparam int DW = 8;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          load_req = 1'b0;
  logic          store_req = 1'b0;
  logic [AW-1:0] dmar = '0;
  logic [DW-1:0] acc_out = '0;
  logic [DW-1:0] acc_in;
  logic          acc_write_enable;
  logic          busy;
  logic          done;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          mem_error;

  data_mem_access_unit #(.DATA_W(DW), .D_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset_n(reset_n), .load_req(load_req), .store_req(store_req),
    .dmar(dmar), .acc_out(acc_out), .acc_in(acc_in), .acc_write_enable(acc_write_enable),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            req_cycles;
  } req_t;

  typedef struct {
    logic          awe;
    logic [DW-1:0] acc;
    logic          err;
  } cpl_t;

  req_t req_q[$];
  cpl_t cpl_q[$];
  int   dly_q[$];

  logic [DW-1:0] mem_arr [4096];
  logic [DW-1:0] ref_mem [4096];
  logic [DW-1:0] ref_acc = '0;

  int n_vec = 0;
  int n_err = 0;
  int cycle = 0;
  bit sb_off = 1'b1;
  bit manual = 1'b0;
  int issue_cycle = 0;

  always @(posedge clk) cycle++;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endfunction

  // Memory responder: acks after a per-access delay taken from dly_q.
  bit rsp_active = 1'b0;
  int rsp_cnt = 0;
  always @(negedge clk) begin
    if (!manual) begin
      if (mem_req) begin
        if (!rsp_active) begin
          rsp_active = 1'b1;
          rsp_cnt = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
        end
        if (rsp_cnt == 0) begin
          mem_ack = 1'b1;
          mem_rdata = mem_arr[mem_addr];
          if (mem_we) mem_arr[mem_addr] = mem_wdata;
          rsp_active = 1'b0;
        end else begin
          mem_ack = 1'b0;
          mem_rdata = 8'($urandom);
          rsp_cnt--;
        end
      end else begin
        mem_ack = 1'b0;
        mem_rdata = 8'($urandom);
        rsp_active = 1'b0;
      end
    end
  end

  // Monitor: pops expectations when an access starts and when done pulses.
  req_t cur;
  cpl_t cpl;
  bit   prev_req = 1'b0;
  int   req_cnt = 0;
  always @(negedge clk) begin
    if (reset_n && !sb_off) begin
      if (mem_req) begin
        if (!prev_req) begin
          check("access_expected", 32'(req_q.size() > 0), 32'd1);
          if (req_q.size() > 0) cur = req_q.pop_front();
          req_cnt = 0;
        end
        req_cnt++;
        check("mem_we", 32'(mem_we), 32'(cur.we));
        check("mem_addr", 32'(mem_addr), 32'(cur.addr));
        check("mem_wdata", 32'(mem_wdata), 32'(cur.wdata));
      end
      if (prev_req && !mem_req) begin
        check("req_cycles", 32'(req_cnt), 32'(cur.req_cycles));
        check("done_after_req", 32'(done), 32'd1);
      end
      if (done) begin
        check("done_expected", 32'(cpl_q.size() > 0), 32'd1);
        if (cpl_q.size() > 0) begin
          cpl = cpl_q.pop_front();
          check("acc_write_enable", 32'(acc_write_enable), 32'(cpl.awe));
          check("acc_in", 32'(acc_in), 32'(cpl.acc));
          check("mem_error", 32'(mem_error), 32'(cpl.err));
        end
      end else begin
        check("awe_without_done", 32'(acc_write_enable), 32'd0);
        check("err_without_done", 32'(mem_error), 32'd0);
      end
      check("busy", 32'(busy), 32'(mem_req | done));
    end
    prev_req = mem_req;
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", 32'(n < 200), 32'd1);
  endtask

  task automatic issue(input bit ld, input bit st, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int dly, input int exp_cycles, input bit exp_err, input bit pulse);
    req_t r;
    cpl_t c;
    wait_idle();
    r.we = st;
    r.addr = a;
    r.wdata = d;
    r.req_cycles = exp_cycles;
    if (exp_err) begin
      c.awe = 1'b0; c.acc = ref_acc; c.err = 1'b1;
    end else if (st) begin
      ref_mem[a] = d;
      c.awe = 1'b0; c.acc = ref_acc; c.err = 1'b0;
    end else begin
      ref_acc = ref_mem[a];
      c.awe = 1'b1; c.acc = ref_acc; c.err = 1'b0;
    end
    req_q.push_back(r);
    cpl_q.push_back(c);
    dly_q.push_back(dly);
    load_req = ld;
    store_req = st;
    dmar = a;
    acc_out = d;
    issue_cycle = cycle;
    @(negedge clk);
    load_req = 1'b0;
    store_req = 1'b0;
    check("req_latency", 32'(mem_req), 32'd1);
    dmar = 12'($urandom);
    acc_out = 8'($urandom);
    if (pulse) begin
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c1;
    for (int i = 0; i < 4096; i++) begin
      mem_arr[i] = 8'($urandom);
      ref_mem[i] = mem_arr[i];
    end
    #1 reset_n = 1'b0;
    #11;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_acc_in", 32'(acc_in), 32'd0);
    check("rst_awe", 32'(acc_write_enable), 32'd0);
    check("rst_mem_error", 32'(mem_error), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    sb_off = 1'b0;

    // Zero-wait load of 0xA5 from 0x234
    mem_arr[12'h234] = 8'hA5;
    ref_mem[12'h234] = 8'hA5;
    issue(1'b1, 1'b0, 12'h234, 8'h11, 0, 1, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_done", 32'(done), 32'd1);
    check("t1_awe", 32'(acc_write_enable), 32'd1);
    check("t1_acc_in", 32'(acc_in), 32'hA5);
    @(negedge clk);
    check("t1_busy_low", 32'(busy), 32'd0);

    // Store with a 4-cycle wait, plus an ignored load pulse while busy
    issue(1'b0, 1'b1, 12'h1FF, 8'h3C, 4, 5, 1'b0, 1'b1);

    // Both requests: store wins
    issue(1'b1, 1'b1, 12'h0A0, 8'h5A, 1, 2, 1'b0, 1'b1);

    // Reset in the 2nd ACCESS cycle of a load
    wait_idle();
    sb_off = 1'b1;
    load_req = 1'b1;
    dmar = 12'h155;
    dly_q.push_back(50);
    @(negedge clk);
    load_req = 1'b0;
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("rstmid_mem_req", 32'(mem_req), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    check("rstmid_acc_in", 32'(acc_in), 32'd0);
    repeat (2) @(negedge clk);
    manual = 1'b1;
    reset_n = 1'b1;
    ref_acc = '0;
    @(negedge clk);
    mem_ack = 1'b1;
    mem_rdata = 8'hEE;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (4) begin
      check("late_ack_done", 32'(done), 32'd0);
      check("late_ack_awe", 32'(acc_write_enable), 32'd0);
      check("late_ack_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end
    manual = 1'b0;
    dly_q.delete();
    sb_off = 1'b0;
    issue(1'b1, 1'b0, 12'h155, 8'h00, 2, 3, 1'b0, 1'b0);

`ifdef DMEM_TIMEOUT_EN
    // Ack never arrives: abort after 15 request cycles; then ack on the last allowed cycle
    issue(1'b1, 1'b0, 12'h321, 8'h00, 100, 15, 1'b1, 1'b0);
    issue(1'b1, 1'b0, 12'h322, 8'h00, 14, 15, 1'b0, 1'b0);
`endif

    // Back-to-back load then store, zero wait
    issue(1'b1, 1'b0, 12'h010, 8'h00, 0, 1, 1'b0, 1'b0);
    c1 = issue_cycle;
    issue(1'b0, 1'b1, 12'h011, 8'h77, 0, 1, 1'b0, 1'b0);
    check("b2b_gap", 32'(issue_cycle - c1), 32'd3);
    wait_idle();
    check("acc_hold_after_store", 32'(acc_in), 32'(ref_acc));

    // Randomized traffic over a small address window so loads hit earlier stores
    for (int i = 0; i < 60; i++) begin
      int k;
      int dly;
      logic [AW-1:0] a;
      k = $urandom_range(0, 3);
      dly = $urandom_range(0, 4);
      a = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 31)) : 12'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue((k != 2), (k >= 2), a, 8'($urandom), dly, dly + 1, 1'b0, ($urandom_range(0, 3) == 0));
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("req_q_drained", 32'(req_q.size()), 32'd0);
    check("cpl_q_drained", 32'(cpl_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
